// File: rtl/uart_rx_frame.sv
`timescale 1ns/1ps
// UART receiver: 8N1 frames, 16x oversampling, mid-bit sampling.
// Ports: CLOCK_50 clock, reset async active-low, RxIn serial line,
//   Enable receiver enable, DataOut last good byte, charRX byte strobe,
//   FrameError bad-stop strobe, Busy high while a frame is in progress.
module uart_rx_frame #(
    parameter int CLKS_PER_TICK = 27
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       RxIn,
    input  logic       Enable,
    output logic [7:0] DataOut,
    output logic       charRX,
    output logic       FrameError,
    output logic       Busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLKS_PER_TICK - 1);

    state_t     state;
    logic       rx_m;
    logic       rx_s;
    logic [7:0] div_cnt;
    logic       tick;
    logic [3:0] tick_cnt;
    // bit 3 is the done flag, so the 8th sample never aliases to bit 0
    logic [3:0] bit_cnt;
    logic [3:0] bit_nxt;
    logic [7:0] shreg;

    assign tick    = (div_cnt == DIV_LAST);
    assign bit_nxt = bit_cnt + 4'd1;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RxIn;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            div_cnt    <= 8'd0;
            tick_cnt   <= 4'd0;
            bit_cnt    <= 4'd0;
            shreg      <= 8'h00;
            DataOut    <= 8'h00;
            charRX     <= 1'b0;
            FrameError <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            charRX     <= 1'b0;
            FrameError <= 1'b0;
            div_cnt    <= tick ? 8'd0 : div_cnt + 8'd1;
            if (!Enable) begin
                state <= S_IDLE;
                Busy  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (!rx_s) begin
                            // phase the divider to the detected edge
                            state    <= S_START;
                            Busy     <= 1'b1;
                            div_cnt  <= 8'd0;
                            tick_cnt <= 4'd0;
                        end
                    end
                    S_START: begin
                        if (tick) begin
                            if (tick_cnt == 4'd7) begin
                                if (rx_s) begin
                                    state <= S_IDLE;
                                    Busy  <= 1'b0;
                                end else begin
                                    state    <= S_DATA;
                                    tick_cnt <= 4'd0;
                                    bit_cnt  <= 4'd0;
                                end
                            end else begin
                                tick_cnt <= tick_cnt + 4'd1;
                            end
                        end
                    end
                    S_DATA: begin
                        if (tick) begin
                            tick_cnt <= tick_cnt + 4'd1;
                            if (tick_cnt == 4'd15) begin
                                shreg   <= {rx_s, shreg[7:1]};
                                bit_cnt <= bit_nxt;
                                if (bit_nxt[3]) begin
                                    state <= S_STOP;
                                end
                            end
                        end
                    end
                    S_STOP: begin
                        if (tick) begin
                            tick_cnt <= tick_cnt + 4'd1;
                            if (tick_cnt == 4'd15) begin
                                if (rx_s) begin
                                    DataOut <= shreg;
                                    charRX  <= 1'b1;
                                    state   <= S_IDLE;
                                    Busy    <= 1'b0;
                                end else begin
                                    FrameError <= 1'b1;
                                    state      <= S_BREAK;
                                end
                            end
                        end
                    end
                    S_BREAK: begin
                        // a held-low line must not look like a new start bit
                        if (rx_s) begin
                            state <= S_IDLE;
                            Busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
`timescale 1ns/1ps
// Testbench for uart_rx_frame: table vectors, corner sequences,
// and random frames against a frame-level reference model.
module tb_uart_rx_frame;

    localparam int C   = 4;
    localparam int BIT = 16 * C;
    // falling edge to strobe: 3 clocks to START, stop sampled 152 ticks later
    localparam int LAT = 3 + (8 + 16 * 9) * C;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic       RxIn     = 1'b1;
    logic       Enable   = 1'b1;
    logic [7:0] DataOut;
    logic       charRX;
    logic       FrameError;
    logic       Busy;

    int cyc  = 0;
    int nvec = 0;
    int nmis = 0;

    typedef struct {
        int         c;
        logic [7:0] d;
    } ev_t;

    ev_t ch_q[$];
    int  fe_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        int         exp_char;
        int         exp_fe;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[8];
    logic [7:0] last_good;

    uart_rx_frame #(.CLKS_PER_TICK(C)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .RxIn      (RxIn),
        .Enable    (Enable),
        .DataOut   (DataOut),
        .charRX    (charRX),
        .FrameError(FrameError),
        .Busy      (Busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (charRX === 1'b1) ch_q.push_back('{cyc, DataOut});
        if (FrameError === 1'b1) fe_q.push_back(cyc);
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded 100000 cycles");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop,
                               output int t0);
        logic [9:0] f;
        f  = {stop, d, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            RxIn = f[i];
            idle(BIT);
        end
    endtask

    // a bad stop bit is followed by a long break before the line recovers
    task automatic break_release(input string nm);
        idle(200);
        chk({nm, " Busy in break"}, int'(Busy), 1);
        RxIn = 1'b1;
        idle(4);
        chk({nm, " Busy after break"}, int'(Busy), 0);
    endtask

    task automatic check_frame(input string nm, input int t0,
                               input int ec, input int ef,
                               input logic [7:0] ed);
        chk({nm, " charRX count"}, ch_q.size(), ec);
        chk({nm, " FrameError count"}, fe_q.size(), ef);
        if (ch_q.size() > 0) begin
            chk({nm, " charRX cycle"}, ch_q[0].c, t0 + LAT);
            chk({nm, " charRX data"}, int'(ch_q[0].d), int'(ed));
        end
        if (fe_q.size() > 0) begin
            chk({nm, " FrameError cycle"}, fe_q[0], t0 + LAT);
        end
        chk({nm, " DataOut"}, int'(DataOut), int'(ed));
        ch_q.delete();
        fe_q.delete();
    endtask

    initial begin
        int         t0;
        int         tr;
        logic [7:0] d;
        logic       stp;

        tbl[0] = '{8'hA5, 1'b1, 100, 1, 0, 8'hA5};
        tbl[1] = '{8'h00, 1'b1, 0,   1, 0, 8'h00};
        tbl[2] = '{8'hFF, 1'b1, 50,  1, 0, 8'hFF};
        tbl[3] = '{8'h3C, 1'b0, 30,  0, 1, 8'hFF};
        tbl[4] = '{8'h11, 1'b1, 10,  1, 0, 8'h11};
        tbl[5] = '{8'h80, 1'b1, 0,   1, 0, 8'h80};
        tbl[6] = '{8'h01, 1'b1, 25,  1, 0, 8'h01};
        tbl[7] = '{8'h7E, 1'b0, 40,  0, 1, 8'h01};

        idle(5);
        chk("reset DataOut", int'(DataOut), 0);
        chk("reset charRX", int'(charRX), 0);
        chk("reset FrameError", int'(FrameError), 0);
        chk("reset Busy", int'(Busy), 0);
        reset = 1'b1;
        idle(20);
        chk("idle Busy", int'(Busy), 0);

        for (int i = 0; i < 8; i++) begin
            drive_frame(tbl[i].data, tbl[i].stop, t0);
            if (!tbl[i].stop) break_release($sformatf("tbl%0d", i));
            check_frame($sformatf("tbl%0d", i), t0, tbl[i].exp_char,
                        tbl[i].exp_fe, tbl[i].exp_data);
            if (tbl[i].gap > 0) idle(tbl[i].gap);
        end
        last_good = 8'h01;

        // short low glitch on an idle line
        RxIn = 1'b0;
        idle(10);
        chk("glitch Busy high", int'(Busy), 1);
        idle(10);
        RxIn = 1'b1;
        idle(20);
        chk("glitch Busy low", int'(Busy), 0);
        chk("glitch charRX count", ch_q.size(), 0);
        chk("glitch FrameError count", fe_q.size(), 0);
        chk("glitch DataOut", int'(DataOut), int'(last_good));
        idle(30);

        // Enable dropped during data bit 4
        fork
            drive_frame(8'h5A, 1'b1, tr);
            begin
                idle(5 * BIT + 20);
                chk("enable Busy before drop", int'(Busy), 1);
                Enable = 1'b0;
                idle(1);
                chk("enable Busy after drop", int'(Busy), 0);
            end
        join
        chk("enable charRX count", ch_q.size(), 0);
        chk("enable FrameError count", fe_q.size(), 0);
        chk("enable DataOut", int'(DataOut), int'(last_good));
        Enable = 1'b1;
        idle(20);
        drive_frame(8'h5A, 1'b1, t0);
        last_good = 8'h5A;
        check_frame("enable 5A", t0, 1, 0, last_good);
        idle(20);

        // asynchronous reset during data bit 2
        fork
            drive_frame(8'h77, 1'b1, tr);
            begin
                idle(3 * BIT + 20);
                chk("rst Busy before", int'(Busy), 1);
                #3;
                reset = 1'b0;
                #1;
                chk("rst DataOut", int'(DataOut), 0);
                chk("rst Busy", int'(Busy), 0);
                chk("rst charRX", int'(charRX), 0);
                chk("rst FrameError", int'(FrameError), 0);
            end
        join
        idle(1);
        reset = 1'b1;
        chk("rst charRX count", ch_q.size(), 0);
        chk("rst FrameError count", fe_q.size(), 0);
        ch_q.delete();
        fe_q.delete();
        last_good = 8'h00;
        idle(20);
        drive_frame(8'hC3, 1'b1, t0);
        last_good = 8'hC3;
        check_frame("rst C3", t0, 1, 0, last_good);

        // random frames: good frames update the byte, bad ones keep it
        for (int k = 0; k < 24; k++) begin
            d   = 8'($urandom);
            stp = ($urandom_range(0, 4) != 0);
            drive_frame(d, stp, t0);
            if (!stp) break_release($sformatf("rnd%0d", k));
            if (stp) last_good = d;
            check_frame($sformatf("rnd%0d", k), t0, int'(stp),
                        int'(!stp), last_good);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 80));
        end

        idle(10);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
